// File: rtl/aixh_mxc_inner_fwd_skew_if.sv
// Activation column stream into the MxConv west-edge feeder.
// The producer (master) offers one column per cycle; the feeder (slave) answers with o_rdy.
interface aixh_mxc_inner_fwd_skew_if #(
    parameter int YCELLS = 8,
    parameter int CWIDTH = 4,
    parameter int DWIDTH = 16
);
    logic                     i_vld;
    logic                     o_rdy;
    logic                     i_last;
    logic [CWIDTH-1:0]        i_cmd;
    logic [YCELLS*DWIDTH-1:0] i_dat;

    modport master (
        output i_vld,
        output i_last,
        output i_cmd,
        output i_dat,
        input  o_rdy
    );

    modport slave (
        input  i_vld,
        input  i_last,
        input  i_cmd,
        input  i_dat,
        output o_rdy
    );
endinterface

// File: rtl/aixh_mxc_inner_fwd_skew.sv
// West-edge feeder for the MxConv inner tile array: row y is delayed y cycles (systolic skew),
// and a drain gap separates consecutive passes inside the array.
module aixh_mxc_inner_fwd_skew #(
    parameter int YCELLS = 8,
    parameter int CWIDTH = 4,
    parameter int DWIDTH = 16,
    parameter int GAP    = 2
) (
    input  logic                      aixh_core_clk2x,
    input  logic                      aixh_core_rstn,
    aixh_mxc_inner_fwd_skew_if.slave  act,
    output logic [YCELLS*CWIDTH-1:0]  o_fwd_cmd,
    output logic [YCELLS*DWIDTH-1:0]  o_fwd_dat,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [15:0]               o_beats
);

    localparam int DRAIN_LOAD = YCELLS - 1 + GAP;
    localparam int CNT_W      = (DRAIN_LOAD > 0) ? $clog2(DRAIN_LOAD + 1) : 1;
    localparam bit DRAIN_NONE = (DRAIN_LOAD == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CWIDTH-1:0] cmd;
        logic [DWIDTH-1:0] dat;
    } slot_t;

    state_t           state;
    logic [CWIDTH-1:0] unused_cmd_w;
    logic [CNT_W-1:0] drain_cnt;
    logic             rdy_q;
    logic             accept;

    assign act.o_rdy = rdy_q;
    assign accept    = act.i_vld & rdy_q;
    assign unused_cmd_w = '0;

    // Control FSM. Outputs are registered from the next-state decision, so o_rdy rises in the
    // final drain cycle (count 0) together with o_done, letting the next pass start there.
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            state     <= IDLE;
            drain_cnt <= '0;
            rdy_q     <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_beats   <= '0;
        end else begin
            // NOTE: every register here uses <= so all updates see this cycle's values;
            // mixing in = would make results depend on statement order.
            o_done <= 1'b0;
            if (accept) begin
                // A beat outside STREAM (IDLE, or the count-0 drain cycle) opens a new pass.
                if (state == STREAM) begin
                    o_beats <= (o_beats == 16'hFFFF) ? o_beats : o_beats + 16'd1;
                end else begin
                    o_beats <= 16'd1;
                end
                o_busy <= 1'b1;
                if (act.i_last) begin
                    state     <= DRAIN;
                    drain_cnt <= CNT_W'(DRAIN_LOAD);
                    rdy_q     <= DRAIN_NONE;
                    o_done    <= DRAIN_NONE;
                end else begin
                    state     <= STREAM;
                    drain_cnt <= '0;
                    rdy_q     <= 1'b1;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        rdy_q  <= 1'b1;
                        o_busy <= 1'b0;
                    end
                    STREAM: begin
                        rdy_q  <= 1'b1;
                        o_busy <= 1'b1;
                    end
                    DRAIN: begin
                        if (drain_cnt == '0) begin
                            state  <= IDLE;
                            rdy_q  <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - CNT_W'(1);
                            if (drain_cnt == CNT_W'(1)) begin
                                rdy_q  <= 1'b1;
                                o_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        drain_cnt <= '0;
                        rdy_q     <= 1'b1;
                        o_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Skew chains: row y has y+1 stages and shifts every cycle; a non-accept cycle loads a NOP.
    for (genvar y = 0; y < YCELLS; y++) begin : g_row
        slot_t chain [0:y];
        slot_t head;

        always_comb begin
            head = '0;
            if (accept) begin
                head.cmd = act.i_cmd;
                head.dat = act.i_dat[y*DWIDTH +: DWIDTH];
            end
        end

        always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
            if (!aixh_core_rstn) begin
                // NOTE: the chains are reset, not left as uninitialised storage, because they
                // drive the array directly and a reset must flush in-flight columns to NOPs.
                for (int i = 0; i <= y; i++) begin
                    chain[i] <= '0;
                end
            end else begin
                chain[0] <= head;
                for (int i = 1; i <= y; i++) begin
                    chain[i] <= chain[i-1];
                end
            end
        end

        assign o_fwd_cmd[y*CWIDTH +: CWIDTH] = chain[y].cmd;
        assign o_fwd_dat[y*DWIDTH +: DWIDTH] = chain[y].dat;
    end

endmodule

// File: tb/tb_aixh_mxc_inner_fwd_skew.sv
// Directed self-checking bench for aixh_mxc_inner_fwd_skew (YCELLS=8, CWIDTH=4, DWIDTH=16, GAP=2).
module tb_aixh_mxc_inner_fwd_skew;

    localparam int YC = 8;
    localparam int CW = 4;
    localparam int DW = 16;

    logic            clk;
    logic            rstn;
    logic [YC*CW-1:0] fwd_cmd;
    logic [YC*DW-1:0] fwd_dat;
    logic            busy;
    logic            done;
    logic [15:0]     beats;

    int n_checks;
    int n_errors;

    aixh_mxc_inner_fwd_skew_if #(.YCELLS(YC), .CWIDTH(CW), .DWIDTH(DW)) act ();

    aixh_mxc_inner_fwd_skew #(.YCELLS(YC), .CWIDTH(CW), .DWIDTH(DW), .GAP(2)) dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rstn  (rstn),
        .act             (act),
        .o_fwd_cmd       (fwd_cmd),
        .o_fwd_dat       (fwd_dat),
        .o_busy          (busy),
        .o_done          (done),
        .o_beats         (beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic l, input logic [CW-1:0] c, input logic [YC*DW-1:0] d);
        act.i_vld  = v;
        act.i_last = l;
        act.i_cmd  = c;
        act.i_dat  = d;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    // Column data where row y carries base + y.
    function automatic logic [YC*DW-1:0] col(input int base);
        logic [YC*DW-1:0] d;
        for (int y = 0; y < YC; y++) d[y*DW +: DW] = 16'(base + y);
        return d;
    endfunction

    initial begin
        logic [YC*CW-1:0] ec;
        logic [YC*DW-1:0] ed;
        int done_seen;
        n_checks = 0;
        n_errors = 0;
        drive(1'b0, 1'b0, '0, '0);

        // Asynchronous reset before any clock edge.
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("rst_cmd", fwd_cmd, 0);
        check("rst_dat", fwd_dat, 0);
        check("rst_rdy_busy_done", {act.o_rdy, busy, done}, 3'b100);
        check("rst_beats", beats, 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Skew: 4 back-to-back beats, cmd 3, row y data 0x100*b+y, last on beat 3.
        for (int k = 0; k <= 13; k++) begin
            if (k < 4) drive(1'b1, k == 3, 4'd3, col(256 * k));
            else       drive(1'b0, 1'b0, '0, '0);
            tick();
            ec = '0;
            ed = '0;
            for (int y = 0; y < YC; y++) begin
                if (k - y >= 0 && k - y <= 3) begin
                    ec[y*CW +: CW] = 4'd3;
                    ed[y*DW +: DW] = 16'(256 * (k - y) + y);
                end
            end
            check($sformatf("skew_cmd_k%0d", k), fwd_cmd, ec);
            check($sformatf("skew_dat_k%0d", k), fwd_dat, ed);
            check($sformatf("skew_ctl_k%0d", k), {act.o_rdy, busy, done},
                  {!(k >= 3 && k <= 11), k <= 12, k == 12});
        end
        check("skew_beats", beats, 16'd4);

        // Bubbles: beat A, two idle cycles, beat B with last.
        for (int k = 0; k <= 13; k++) begin
            if (k == 0)      drive(1'b1, 1'b0, 4'd5, col(16'hA000));
            else if (k == 3) drive(1'b1, 1'b1, 4'd6, col(16'hB000));
            else             drive(1'b0, 1'b0, '0, '0);
            tick();
            ec = '0;
            ed = '0;
            for (int y = 0; y < YC; y++) begin
                if (k == y) begin
                    ec[y*CW +: CW] = 4'd5;
                    ed[y*DW +: DW] = 16'(16'hA000 + y);
                end else if (k == y + 3) begin
                    ec[y*CW +: CW] = 4'd6;
                    ed[y*DW +: DW] = 16'(16'hB000 + y);
                end
            end
            check($sformatf("bub_cmd_k%0d", k), fwd_cmd, ec);
            check($sformatf("bub_dat_k%0d", k), fwd_dat, ed);
        end
        check("bub_beats", beats, 16'd2);
        check("bub_idle", {act.o_rdy, busy, done}, 3'b100);

        // Single-beat pass: STREAM skipped, busy for 10 cycles, done on the 10th.
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) drive(1'b1, 1'b1, 4'd7, col(16'h7700));
            else        drive(1'b0, 1'b0, '0, '0);
            tick();
            if (k == 0) check("single_beats", beats, 16'd1);
            check($sformatf("single_ctl_k%0d", k), {act.o_rdy, busy, done}, {k >= 9, k <= 9, k == 9});
        end

        // Back-to-back: next beat held valid is accepted in the o_done cycle.
        for (int k = 0; k <= 10; k++) begin
            if (k == 0) drive(1'b1, 1'b1, 4'd1, col(16'h1100));
            else        drive(1'b1, 1'b1, 4'd2, col(16'h2200));
            tick();
            check($sformatf("b2b_ctl_k%0d", k), {act.o_rdy, busy, done}, {k == 9, 1'b1, k == 9});
            check($sformatf("b2b_row0_k%0d", k), fwd_cmd[3:0], (k == 0) ? 4'd1 : (k == 10) ? 4'd2 : 4'd0);
        end
        drive(1'b0, 1'b0, '0, '0);
        wait_done("b2b_second_done");
        tick();

        // Saturation: 65540 beats without last.
        drive(1'b1, 1'b0, 4'd1, '0);
        for (int j = 1; j <= 65540; j++) begin
            tick();
            if (j == 100)   check("sat_beats_100", beats, 16'd100);
            if (j == 65535) check("sat_beats_max", beats, 16'hFFFF);
        end
        check("sat_beats_hold", beats, 16'hFFFF);
        drive(1'b1, 1'b1, 4'd1, '0);
        tick();
        check("sat_last_beats", beats, 16'hFFFF);
        drive(1'b0, 1'b0, '0, '0);
        wait_done("sat_done");
        check("sat_drain_beats", beats, 16'hFFFF);
        drive(1'b1, 1'b1, 4'd4, '0);
        tick();
        check("sat_restart_beats", beats, 16'd1);
        drive(1'b0, 1'b0, '0, '0);
        wait_done("restart_done");
        tick();

        // Reset mid-STREAM with loaded chains.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 4'd9, col(16'hC000 + 256 * k));
            tick();
        end
        check("pre_rst_busy", busy, 1'b1);
        drive(1'b0, 1'b0, '0, '0);
        #2 rstn = 1'b0;
        #1;
        check("midrst_cmd", fwd_cmd, 0);
        check("midrst_dat", fwd_dat, 0);
        check("midrst_ctl", {act.o_rdy, busy, done}, 3'b100);
        check("midrst_beats", beats, 0);
        tick();
        rstn = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_chain_flushed", fwd_cmd, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
